// File: rtl/execute.sv
// execute: MIPS execute stage; registers ALU, memory-control and redirect results.
// Optional iterative mul/div unit with HI/LO is built when EXECUTE_MULDIV_EN is defined.
module execute #(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable_execute,
    input  logic [31:0] pc,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic [4:0]  sa,
    input  logic [25:0] imm,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic        valid_out,
    output logic [31:0] alu_result,
    output logic [4:0]  dest_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] store_data,
    output logic        branch_taken,
    output logic [31:0] branch_target
);
    logic        accept, wr, rd_m, wr_m, br;
    logic [31:0] simm, zimm, pc4, res, tgt;
    logic [4:0]  dst;
`ifdef EXECUTE_MULDIV_EN
    logic        md_start;
    logic [31:0] hi, lo;
`endif

    assign accept = enable_execute && !stall;
    assign simm   = {{16{imm[15]}}, imm[15:0]};
    assign zimm   = {16'h0, imm[15:0]};
    assign pc4    = pc + 32'd4;

    always_comb begin
        res  = '0;
        dst  = '0;
        wr   = 1'b0;
        rd_m = 1'b0;
        wr_m = 1'b0;
        br   = 1'b0;
        tgt  = '0;
`ifdef EXECUTE_MULDIV_EN
        md_start = 1'b0;
`endif
        case (opcode)
            6'h00: begin
                dst = rd;
                wr  = 1'b1;
                case (func)
                    6'h00: res = rt_data << sa;
                    6'h02: res = rt_data >> sa;
                    6'h03: res = $signed(rt_data) >>> sa;
                    6'h08: begin wr = 1'b0; br = 1'b1; tgt = rs_data; end
                    6'h20, 6'h21: res = rs_data + rt_data;
                    6'h22, 6'h23: res = rs_data - rt_data;
                    6'h24: res = rs_data & rt_data;
                    6'h25: res = rs_data | rt_data;
                    6'h26: res = rs_data ^ rt_data;
                    6'h27: res = ~(rs_data | rt_data);
                    6'h2a: res = {31'h0, $signed(rs_data) < $signed(rt_data)};
                    6'h2b: res = {31'h0, rs_data < rt_data};
`ifdef EXECUTE_MULDIV_EN
                    6'h10: res = hi;
                    6'h12: res = lo;
                    6'h18, 6'h19, 6'h1a, 6'h1b: begin wr = 1'b0; md_start = 1'b1; end
`endif
                    default: begin dst = '0; wr = 1'b0; end
                endcase
            end
            6'h08, 6'h09: begin dst = rt; wr = 1'b1; res = rs_data + simm; end
            6'h0a: begin dst = rt; wr = 1'b1; res = {31'h0, $signed(rs_data) < $signed(simm)}; end
            6'h0b: begin dst = rt; wr = 1'b1; res = {31'h0, rs_data < simm}; end
            6'h0c: begin dst = rt; wr = 1'b1; res = rs_data & zimm; end
            6'h0d: begin dst = rt; wr = 1'b1; res = rs_data | zimm; end
            6'h0e: begin dst = rt; wr = 1'b1; res = rs_data ^ zimm; end
            6'h0f: begin dst = rt; wr = 1'b1; res = {imm[15:0], 16'h0}; end
            6'h23: begin dst = rt; wr = 1'b1; rd_m = 1'b1; res = rs_data + simm; end
            6'h2b: begin dst = rt; wr_m = 1'b1; res = rs_data + simm; end
            6'h04, 6'h05: begin
                dst = rt;
                tgt = pc4 + {simm[29:0], 2'b00};
                br  = (rs_data == rt_data) ^ opcode[0];
            end
            6'h02, 6'h03: begin
                tgt = {pc4[31:28], imm, 2'b00};
                br  = 1'b1;
                wr  = opcode[0];
                dst = opcode[0] ? 5'd31 : 5'd0;
                res = opcode[0] ? pc + 32'd8 : 32'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_out     <= 1'b0;
            alu_result    <= '0;
            dest_reg      <= '0;
            reg_write     <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            store_data    <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else begin
            valid_out    <= accept;
            reg_write    <= accept && wr && (dst != 5'd0);
            mem_read     <= accept && rd_m;
            mem_write    <= accept && wr_m;
            branch_taken <= accept && br;
            if (accept) begin
                alu_result    <= res;
                dest_reg      <= dst;
                store_data    <= rt_data;
                branch_target <= tgt;
            end
        end
    end

`ifdef EXECUTE_MULDIV_EN
    localparam int CW = $clog2(MULDIV_CYCLES + 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state, state_n;
    logic [CW-1:0] cnt;
    logic [63:0] p, pn, mstep, dstep, prod;
    logic [32:0] msum;
    logic [31:0] a, ms, mt, hi_n, lo_n;
    logic        sgn, is_div, neg_q, neg_r, div0;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        if (state == IDLE && accept && md_start) state_n = BUSY;
        if (state == BUSY && cnt == CW'(1)) state_n = IDLE;
    end

    assign stall = (state == BUSY);
    assign sgn   = !func[0];
    assign ms    = (sgn && rs_data[31]) ? -rs_data : rs_data;
    assign mt    = (sgn && rt_data[31]) ? -rt_data : rt_data;
    // p holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign msum  = {1'b0, p[63:32]} + {1'b0, p[0] ? a : 32'h0};
    assign mstep = {msum, p[31:1]};
    assign dstep = (p[63:31] >= {1'b0, a}) ? {p[62:31] - a, p[30:0], 1'b1} : {p[62:0], 1'b0};
    assign pn    = is_div ? dstep : mstep;
    assign prod  = neg_q ? -pn : pn;
    assign hi_n  = is_div ? (neg_r ? -pn[63:32] : pn[63:32]) : prod[63:32];
    assign lo_n  = is_div ? ((neg_q && !div0) ? -pn[31:0] : pn[31:0]) : prod[31:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            p      <= '0;
            a      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else if (state == IDLE && accept && md_start) begin
            cnt    <= CW'(MULDIV_CYCLES);
            p      <= {32'h0, ms};
            a      <= mt;
            is_div <= func[1];
            neg_q  <= sgn && (rs_data[31] ^ rt_data[31]);
            neg_r  <= sgn && rs_data[31];
            div0   <= (rt_data == 32'h0);
        end else if (state == BUSY) begin
            cnt <= cnt - CW'(1);
            p   <= pn;
            if (cnt == CW'(1)) begin
                hi <= hi_n;
                lo <= lo_n;
            end
        end
    end
`else
    assign stall = 1'b0;
`endif
endmodule

// File: tb/tb_execute.sv
// tb_execute: directed scoreboard bench for execute; expected results queued at issue.
module tb_execute;
    logic        clock = 1'b0, reset_n = 1'b0, enable_execute = 1'b0;
    logic [31:0] pc = '0, rs_data = '0, rt_data = '0;
    logic [5:0]  opcode = '0, func = '0;
    logic [4:0]  sa = '0, rt = '0, rd = '0;
    logic [25:0] imm = '0;
    logic        stall, valid_out, reg_write, mem_read, mem_write, branch_taken;
    logic [31:0] alu_result, store_data, branch_target;
    logic [4:0]  dest_reg;
    int checks = 0, errors = 0, w, n;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  dst;
        logic        rw, mr, mw, bt;
        logic [31:0] tgt;
        logic        ca, cd, ct;
    } exp_t;
    exp_t sb[$];

    execute #(.MULDIV_CYCLES(32)) dut (
        .clock(clock), .reset_n(reset_n), .enable_execute(enable_execute), .pc(pc),
        .opcode(opcode), .func(func), .sa(sa), .imm(imm), .rt(rt), .rd(rd),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .valid_out(valid_out),
        .alu_result(alu_result), .dest_reg(dest_reg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .store_data(store_data),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic [25:0] im, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e, output int waited);
        exp_t x;
        opcode = op; func = fn; sa = s; rt = t; rd = d; imm = im; pc = p;
        rs_data = a; rt_data = b; enable_execute = 1'b1;
        sb.push_back(e);
        waited = 0;
        do begin
            @(posedge clock); #1;
            waited++;
        end while (!valid_out && waited < 200);
        enable_execute = 1'b0;
        x = sb.pop_front();
        chk({tag, ".valid"}, 32'(valid_out), 32'd1);
        chk({tag, ".rw"}, 32'(reg_write), 32'(x.rw));
        chk({tag, ".mr"}, 32'(mem_read), 32'(x.mr));
        chk({tag, ".mw"}, 32'(mem_write), 32'(x.mw));
        chk({tag, ".bt"}, 32'(branch_taken), 32'(x.bt));
        if (x.ca) chk({tag, ".alu"}, alu_result, x.alu);
        if (x.cd) chk({tag, ".dst"}, 32'(dest_reg), 32'(x.dst));
        if (x.ct) chk({tag, ".tgt"}, branch_target, x.tgt);
    endtask

    initial begin
        #12;
        chk("rst.valid", 32'(valid_out), 0);
        chk("rst.stall", 32'(stall), 0);
        chk("rst.alu", alu_result, 0);
        chk("rst.rw", 32'(reg_write), 0);
        chk("rst.tgt", branch_target, 0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;

        send("addiu", 6'h09, 6'h00, 0, 8, 0, 26'h1, 0, 32'h7FFFFFFF, 0,
             exp_t'{32'h80000000, 8, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        @(posedge clock); #1;
        chk("idle.valid", 32'(valid_out), 0);
        chk("idle.rw", 32'(reg_write), 0);
        send("subu", 6'h00, 6'h23, 0, 0, 3, 0, 0, 5, 7,
             exp_t'{32'hFFFFFFFE, 3, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        send("sra", 6'h00, 6'h03, 4, 0, 4, 0, 0, 0, 32'h80000000,
             exp_t'{32'hF8000000, 4, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        send("srl", 6'h00, 6'h02, 4, 0, 4, 0, 0, 0, 32'h80000000,
             exp_t'{32'h08000000, 4, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        send("slt", 6'h00, 6'h2A, 0, 0, 7, 0, 0, 32'hFFFFFFFF, 1,
             exp_t'{1, 7, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        send("sltu", 6'h00, 6'h2B, 0, 0, 7, 0, 0, 32'hFFFFFFFF, 1,
             exp_t'{0, 7, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        send("nor", 6'h00, 6'h27, 0, 0, 9, 0, 0, 32'h0F0F0F0F, 32'h00FF00FF,
             exp_t'{32'hF000F000, 9, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        send("slti", 6'h0A, 6'h00, 0, 9, 0, 26'hFFFF, 0, 32'hFFFFFFFE, 0,
             exp_t'{1, 9, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        send("ori", 6'h0D, 6'h00, 0, 10, 0, 26'h8001, 0, 32'h12340000, 0,
             exp_t'{32'h12348001, 10, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        send("lui", 6'h0F, 6'h00, 0, 2, 0, 26'h1234, 0, 32'hFFFFFFFF, 0,
             exp_t'{32'h12340000, 2, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        send("lw", 6'h23, 6'h00, 0, 5, 0, 26'hFFFC, 0, 32'h1000, 0,
             exp_t'{32'h0FFC, 5, 1, 1, 0, 0, 0, 1, 1, 0}, w);
        send("sw", 6'h2B, 6'h00, 0, 6, 0, 26'h0008, 0, 32'h1000, 32'hDEADBEEF,
             exp_t'{32'h1008, 0, 0, 0, 1, 0, 0, 1, 0, 0}, w);
        chk("sw.data", store_data, 32'hDEADBEEF);
        send("beq_t", 6'h04, 6'h00, 0, 0, 0, 26'hFFFF, 32'h80020000, 5, 5,
             exp_t'{0, 0, 0, 0, 0, 1, 32'h80020000, 0, 0, 1}, w);
        send("beq_n", 6'h04, 6'h00, 0, 0, 0, 26'hFFFF, 32'h80020000, 5, 6,
             exp_t'{0, 0, 0, 0, 0, 0, 32'h80020000, 0, 0, 1}, w);
        send("bne_t", 6'h05, 6'h00, 0, 0, 0, 26'h0004, 32'h1000, 5, 6,
             exp_t'{0, 0, 0, 0, 0, 1, 32'h1014, 0, 0, 1}, w);
        send("j", 6'h02, 6'h00, 0, 0, 0, 26'h0000004, 32'h80020010, 0, 0,
             exp_t'{0, 0, 0, 0, 0, 1, 32'h80000010, 0, 0, 1}, w);
        send("jr", 6'h00, 6'h08, 0, 0, 0, 0, 0, 32'h12345678, 0,
             exp_t'{0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0, 1}, w);
        send("jal", 6'h03, 6'h00, 0, 0, 0, 26'h0008010, 32'h80020010, 0, 0,
             exp_t'{32'h80020018, 31, 1, 0, 0, 1, 32'h80020040, 1, 1, 1}, w);
        send("unk", 6'h3F, 6'h00, 0, 3, 3, 26'h1, 0, 1, 1,
             exp_t'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, w);
        send("sll_r0", 6'h00, 6'h00, 3, 0, 0, 0, 0, 0, 1,
             exp_t'{8, 0, 0, 0, 0, 0, 0, 1, 1, 0}, w);

`ifdef EXECUTE_MULDIV_EN
        send("mult", 6'h00, 6'h18, 0, 0, 0, 0, 0, 32'hFFFFFFFE, 3,
             exp_t'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, w);
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(posedge clock); #1;
        end
        chk("mult.stall_cycles", n, 32);
        send("mflo", 6'h00, 6'h12, 0, 0, 4, 0, 0, 0, 0,
             exp_t'{32'hFFFFFFFA, 4, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        send("mfhi", 6'h00, 6'h10, 0, 0, 5, 0, 0, 0, 0,
             exp_t'{32'hFFFFFFFF, 5, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        send("divu0", 6'h00, 6'h1B, 0, 0, 0, 0, 0, 7, 0,
             exp_t'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, w);
        chk("divu0.stall", 32'(stall), 1);
        send("divu0.lo", 6'h00, 6'h12, 0, 0, 4, 0, 0, 0, 0,
             exp_t'{32'hFFFFFFFF, 4, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        chk("divu0.wait", w, 33);
        send("divu0.hi", 6'h00, 6'h10, 0, 0, 4, 0, 0, 0, 0,
             exp_t'{7, 4, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        send("div", 6'h00, 6'h1A, 0, 0, 0, 0, 0, 32'hFFFFFFF9, 2,
             exp_t'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, w);
        send("div.lo", 6'h00, 6'h12, 0, 0, 6, 0, 0, 0, 0,
             exp_t'{32'hFFFFFFFD, 6, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        send("div.hi", 6'h00, 6'h10, 0, 0, 6, 0, 0, 0, 0,
             exp_t'{32'hFFFFFFFF, 6, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        send("mult2", 6'h00, 6'h18, 0, 0, 0, 0, 0, 32'h12345, 32'h777,
             exp_t'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, w);
        repeat (9) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("rstmid.stall", 32'(stall), 0);
        chk("rstmid.valid", 32'(valid_out), 0);
        chk("rstmid.alu", alu_result, 0);
        chk("rstmid.dst", 32'(dest_reg), 0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        send("rstmid.hi", 6'h00, 6'h10, 0, 0, 7, 0, 0, 0, 0,
             exp_t'{0, 7, 1, 0, 0, 0, 0, 1, 1, 0}, w);
        chk("rstmid.wait", w, 1);
`else
        send("mult_off", 6'h00, 6'h18, 0, 0, 3, 0, 0, 32'hFFFFFFFE, 3,
             exp_t'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, w);
        chk("mult_off.stall", 32'(stall), 0);
        send("mfhi_off", 6'h00, 6'h10, 0, 0, 5, 0, 0, 0, 0,
             exp_t'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, w);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
